// File: rtl/shift_pkg.sv
// shift_pkg
//   Shared definitions for the shift issue/capture stage:
//   - op-code encodings (bit 2 selects register amount, bits [1:0] the kind)
//   - shifter mode (aluc) encodings expected by the barrel shifter
//   - out_entry_t, one output-buffer entry {data, tag, err}
//   - op_to_aluc(), maps the op kind bits onto the shifter mode
package shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned AMT_W  = 5;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b100;
  localparam logic [2:0] OP_SRLV = 3'b101;
  localparam logic [2:0] OP_SRAV = 3'b110;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b10;
  localparam logic [1:0] ALUC_SLL = 2'b01;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } out_entry_t;

  // Kind bits 2'b11 fall through to a left shift; they are only treated as
  // illegal by the caller when error reporting is built in.
  function automatic logic [1:0] op_to_aluc(input logic [1:0] kind);
    logic [1:0] aluc;
    aluc = ALUC_SLL;
    if (kind == OP_SRL[1:0]) begin
      aluc = ALUC_SRL;
    end else if (kind == OP_SRA[1:0]) begin
      aluc = ALUC_SRA;
    end
    return aluc;
  endfunction

endpackage

// File: rtl/shift_out_fifo.sv
// shift_out_fifo
//   Two-entry output buffer for shift results.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     flush         - empties the buffer (pointers and count to 0), no pop
//     push          - write push_entry at the tail (caller guarantees room,
//                     push with pop while full is allowed)
//     push_entry    - entry to write
//     pop           - drop the head entry
//     head_entry    - current head entry (entry storage resets to 0)
//     cnt           - registered occupancy, 0..2
module shift_out_fifo
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  out_entry_t push_entry,
  input  logic       pop,
  output out_entry_t head_entry,
  output logic [1:0] cnt
);

  out_entry_t mem_q [2];
  out_entry_t mem_d [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = '0;
    end else begin
      // When full, wr_q == rd_q, so a simultaneous push overwrites the slot
      // being popped while the head moves to the other slot.
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_entry = mem_q[rd_q];
  assign cnt        = cnt_q;

endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Issue/capture stage around an external combinational 32-bit barrel
//   shifter. Decoded shift ops are accepted over in_valid/in_ready into the
//   issue slot S1, which drives the shifter directly; the shifter result is
//   captured into a 2-entry buffer drained via out_valid/out_ready.
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     flush               - discard S1 and buffer contents
//     in_valid/in_ready   - input handshake
//     in_op               - op code (bit 2: amount from register)
//     in_data             - operand
//     in_amt_imm          - immediate amount
//     in_amt_reg          - register amount, only [4:0] used
//     in_tag              - destination tag
//     sh_a, sh_b, sh_aluc - shifter operand, amount, mode (from S1 flops)
//     sh_c                - shifter result, sampled when S1 advances
//     out_valid/out_ready - output handshake
//     out_data, out_tag   - head entry of the output buffer
//     out_err             - illegal-op flag (only with SHIFT_ERR_EN)
//   Build option: SHIFT_ERR_EN makes op kinds 2'b11 illegal; they push data 0
//   with err set and drive the shifter as SLL by 0.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [DW-1:0] in_data,
  input  logic [4:0]    in_amt_imm,
  input  logic [DW-1:0] in_amt_reg,
  input  logic [TW-1:0] in_tag,
  output logic [31:0]   sh_a,
  output logic [4:0]    sh_b,
  output logic [1:0]    sh_aluc,
  input  logic [31:0]   sh_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [TW-1:0] out_tag
`ifdef SHIFT_ERR_EN
  ,
  output logic          out_err
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_a_q, s1_a_d;
  logic [AMT_W-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_aluc_q, s1_aluc_d;
  logic [TW-1:0]    s1_tag_q, s1_tag_d;
  logic             s1_err_q, s1_err_d;

  logic             op_illegal;
  logic [AMT_W-1:0] dec_amt;
  logic [1:0]       dec_aluc;

  logic             accept;
  logic             pop;
  logic             s1_adv;
  logic [1:0]       fifo_cnt;
  out_entry_t       push_entry;
  out_entry_t       head_entry;

  logic             unused_amt_hi;
  assign unused_amt_hi = ^in_amt_reg[DW-1:AMT_W];

  // Decode
  always_comb begin
    op_illegal = 1'b0;
`ifdef SHIFT_ERR_EN
    op_illegal = (in_op[1:0] == 2'b11);
`endif
    dec_amt  = in_op[2] ? in_amt_reg[AMT_W-1:0] : in_amt_imm;
    dec_aluc = op_to_aluc(in_op[1:0]);
    if (op_illegal) begin
      dec_amt  = '0;
      dec_aluc = ALUC_SLL;
    end
  end

  // Handshake. in_ready reaches out_ready only through pop -> s1_adv.
  assign pop      = out_valid && out_ready;
  assign s1_adv   = s1_valid_q && ((fifo_cnt < 2'd2) || pop);
  assign in_ready = !flush && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  // Issue slot; payload holds its value while empty so sh_* stay stable.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_aluc_d  = s1_aluc_q;
    s1_tag_d   = s1_tag_q;
    s1_err_d   = s1_err_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_a_d     = in_data;
        s1_b_d     = dec_amt;
        s1_aluc_d  = dec_aluc;
        s1_tag_d   = in_tag;
        s1_err_d   = op_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_aluc_q  <= ALUC_SRA;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_aluc_q  <= s1_aluc_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
    end
  end

  assign sh_a    = s1_a_q;
  assign sh_b    = s1_b_q;
  assign sh_aluc = s1_aluc_q;

  // Capture
  always_comb begin
    push_entry.data = s1_err_q ? '0 : sh_c;
    push_entry.tag  = s1_tag_q;
    push_entry.err  = s1_err_q;
  end

  shift_out_fifo u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (s1_adv),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .cnt        (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = head_entry.data;
  assign out_tag   = head_entry.tag;

`ifdef SHIFT_ERR_EN
  assign out_err = head_entry.err;
`else
  logic unused_head_err;
  assign unused_head_err = head_entry.err;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt_imm;
  logic [31:0] in_amt_reg;
  logic [4:0]  in_tag;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic [1:0]  sh_aluc;
  logic [31:0] sh_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef SHIFT_ERR_EN
  logic        out_err;
`endif

  int checks   = 0;
  int failures = 0;

  shift_issue_stage #(.DW(32), .TW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_amt_imm (in_amt_imm),
    .in_amt_reg (in_amt_reg),
    .in_tag     (in_tag),
    .sh_a       (sh_a),
    .sh_b       (sh_b),
    .sh_aluc    (sh_aluc),
    .sh_c       (sh_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
`ifdef SHIFT_ERR_EN
    ,
    .out_err    (out_err)
`endif
  );

  // Barrel shifter model: 00 arithmetic right, 10 logical right, else left.
  always_comb begin
    case (sh_aluc)
      2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
      2'b10:   sh_c = sh_a >> sh_b;
      default: sh_c = sh_a << sh_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [4:0] imm,
                       input logic [31:0] r, input logic [4:0] tag);
    in_valid   = 1'b1;
    in_op      = op;
    in_data    = d;
    in_amt_imm = imm;
    in_amt_reg = r;
    in_tag     = tag;
  endtask

  // Three back-to-back accepts with out_ready low: S1 plus both buffer slots.
  task automatic fill3();
    out_ready = 1'b0;
    issue(3'b000, 32'h3, 5'd1, 32'h0, 5'd20);
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    check("fill_in_ready_low", {63'b0, in_ready}, 64'd0);
  endtask

  int          acc_cnt;
  int          k;
  int          idx;
  int          first_cyc;
  int          last_cyc;
  logic        acc_now;
  logic [31:0] exp_data;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_data = '0; in_amt_imm = '0; in_amt_reg = '0; in_tag = '0;
    tick();
    tick();
    check("rst_in_ready",  {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data",  {32'b0, out_data}, 64'd0);
    check("rst_out_tag",   {59'b0, out_tag}, 64'd0);
    check("rst_sh_a",      {32'b0, sh_a}, 64'd0);
    check("rst_sh_b",      {59'b0, sh_b}, 64'd0);
    check("rst_sh_aluc",   {62'b0, sh_aluc}, 64'd0);
`ifdef SHIFT_ERR_EN
    check("rst_out_err",   {63'b0, out_err}, 64'd0);
`endif
    rst = 1'b0;

    // SRA by immediate 4
    out_ready = 1'b1;
    issue(3'b010, 32'h8000_0000, 5'd4, 32'h0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("sra_sh_aluc", {62'b0, sh_aluc}, 64'd0);
    check("sra_sh_b",    {59'b0, sh_b}, 64'd4);
    check("sra_sh_a",    {32'b0, sh_a}, 64'h8000_0000);
    check("sra_n1_out_valid", {63'b0, out_valid}, 64'd0);
    tick();
    check("sra_out_valid", {63'b0, out_valid}, 64'd1);
    check("sra_out_data",  {32'b0, out_data}, 64'hF800_0000);
    check("sra_out_tag",   {59'b0, out_tag}, 64'd3);

    // SLLV then SRLV, register amount uses only [4:0] (= 8)
    issue(3'b100, 32'h0000_00FF, 5'd0, 32'hFFFF_FFE8, 5'd1);
    tick();
    issue(3'b101, 32'h0000_00FF, 5'd0, 32'hFFFF_FFE8, 5'd2);
    tick();
    in_valid = 1'b0;
    check("sllv_out_valid", {63'b0, out_valid}, 64'd1);
    check("sllv_out_data",  {32'b0, out_data}, 64'h0000_FF00);
    check("sllv_out_tag",   {59'b0, out_tag}, 64'd1);
    tick();
    check("srlv_out_valid", {63'b0, out_valid}, 64'd1);
    check("srlv_out_data",  {32'b0, out_data}, 64'h0);
    check("srlv_out_tag",   {59'b0, out_tag}, 64'd2);
    tick();
    check("srlv_drained", {63'b0, out_valid}, 64'd0);

    // Amount 0 passes the operand through
    issue(3'b010, 32'h8000_0001, 5'd0, 32'h0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    check("amt0_out_data", {32'b0, out_data}, 64'h8000_0001);
    check("amt0_out_tag",  {59'b0, out_tag}, 64'd4);
    tick();

    // Backpressure: stream SLL of 1 by k+1, tag 10+k
    out_ready = 1'b0;
    acc_cnt   = 0;
    k         = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 4) issue(3'b000, 32'h1, 5'(k + 1), 32'h0, 5'(10 + k));
      else in_valid = 1'b0;
      #1;
      if (in_ready) begin
        acc_cnt++;
        k++;
      end
      tick();
    end
    check("bp_accepted", 64'(acc_cnt), 64'd3);
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);

    out_ready = 1'b1;
    #1;
    idx       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 8; c++) begin
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        exp_data = 32'h1 << (idx + 1);
        check("drain_data", {32'b0, out_data}, {32'b0, exp_data});
        check("drain_tag",  {59'b0, out_tag}, 64'(10 + idx));
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        idx++;
      end
      tick();
      if (acc_now) in_valid = 1'b0;
      #1;
    end
    check("drain_count", 64'(idx), 64'd4);
    check("drain_back_to_back", 64'(last_cyc - first_cyc), 64'd3);
    check("drain_empty", {63'b0, out_valid}, 64'd0);

    // Flush with a full pipeline
    fill3();
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", {63'b0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready",  {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    issue(3'b001, 32'h2, 5'd1, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    tick();
    check("post_flush_valid", {63'b0, out_valid}, 64'd1);
    check("post_flush_data",  {32'b0, out_data}, 64'h1);
    check("post_flush_tag",   {59'b0, out_tag}, 64'd7);
    tick();
    check("post_flush_empty", {63'b0, out_valid}, 64'd0);

    // Reset mid-stream
    fill3();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mrst_in_ready",  {63'b0, in_ready}, 64'd1);
    check("mrst_out_data",  {32'b0, out_data}, 64'd0);
    check("mrst_out_tag",   {59'b0, out_tag}, 64'd0);
    check("mrst_sh_a",      {32'b0, sh_a}, 64'd0);
    check("mrst_sh_b",      {59'b0, sh_b}, 64'd0);
    check("mrst_sh_aluc",   {62'b0, sh_aluc}, 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mrst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    // Op 011
    issue(3'b011, 32'h0000_00F0, 5'd4, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    check("op3_sh_aluc", {62'b0, sh_aluc}, 64'd1);
`ifdef SHIFT_ERR_EN
    check("op3_sh_b", {59'b0, sh_b}, 64'd0);
`else
    check("op3_sh_b", {59'b0, sh_b}, 64'd4);
`endif
    tick();
    check("op3_out_valid", {63'b0, out_valid}, 64'd1);
    check("op3_out_tag",   {59'b0, out_tag}, 64'd9);
`ifdef SHIFT_ERR_EN
    check("op3_out_data", {32'b0, out_data}, 64'd0);
    check("op3_out_err",  {63'b0, out_err}, 64'd1);
`else
    check("op3_out_data", {32'b0, out_data}, 64'h0000_0F00);
`endif
    tick();
    check("op3_drained", {63'b0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Pipelined issue/capture stage wrapped around the team's combinational 32-bit barrel shifter. It accepts decoded shift micro-ops over a valid/ready handshake and resolves the shift amount from an immediate or a register. It drives the shifter's operand, amount and mode inputs from a registered issue slot, then captures the shifter result into a 2-entry output buffer. The writeback stage drains that buffer through its own valid/ready handshake.

## Interface
- `DW`, 32, data width; fixed to 32, matching the shifter.
- `TW`, 5, destination-tag width.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous discard of all in-flight ops.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_op` in 3: op code.
- `in_data` in DW: operand to be shifted.
- `in_amt_imm` in 5: immediate shift amount.
- `in_amt_reg` in DW: register shift amount; only `[4:0]` is used.
- `in_tag` in TW: destination tag.
- `sh_a` out 32, `sh_b` out 5, `sh_aluc` out 2: shifter operand, amount and mode.
- `sh_c` in 32: shifter result.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_data` out DW, `out_tag` out TW.
- `out_err` out 1: illegal op flag; present only with `SHIFT_ERR_EN`.

## Operation
- Op codes:
  - SLL=000, SRL=001, SRA=010.
  - SLLV=100, SRLV=101, SRAV=110.
  - Bit 2 selects the amount source: `in_amt_reg[4:0]` when set, `in_amt_imm` when clear.
- Mode mapping onto `sh_aluc`:
  - SRA/SRAV → 2'b00 (arithmetic right).
  - SRL/SRLV → 2'b10 (logical right).
  - SLL/SLLV → 2'b01 (left).
- Issue slot S1 holds `s1_valid`, operand, resolved 5-bit amount, aluc, tag and err.
  - `sh_a`, `sh_b` and `sh_aluc` are driven directly from the S1 registers.
  - While S1 is empty they hold their last value; at reset they are 0.
- Output buffer: 2-entry FIFO of {data, tag, err}.
  - `out_*` present the head entry.
  - Pop occurs on `out_valid && out_ready`.
- Advancing S1 into the FIFO:
  - `s1_adv = s1_valid && (cnt < 2 || pop)`.
  - On advance, `sh_c` (or 0 for an illegal op) is pushed.
- `in_ready = !flush && (!s1_valid || s1_adv)`.
- Accept occurs on `in_valid && in_ready`; the decoded fields load into S1.
- Simultaneous accept and advance in the same cycle gives full throughput: one op per cycle.
- Simultaneous push and pop with `cnt==2` is allowed; `cnt` stays at 2.
- `flush`, evaluated in the same edge:
  - clears `s1_valid` and sets FIFO `cnt=0`;
  - does not pop, and drops any accept because `in_ready` is low.
- Amount 0 passes the operand through unchanged. Amounts above 31 cannot occur, because only 5 bits are taken.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`.
  - `out_data=0`, `out_tag=0`, `out_err=0`.
  - `sh_a=0`, `sh_b=0`, `sh_aluc=2'b00`.
  - `s1_valid=0`, `cnt=0`.
- Latency: an op accepted at edge N has `sh_*` valid in cycle N+1 and appears on `out_*` in cycle N+2 if the FIFO was empty.
- No combinational path from `out_ready` to `in_ready` other than through `s1_adv`. `in_ready` depends on `flush`, `s1_valid`, `cnt` and `pop`.
- `sh_c` is sampled only on the S1 advance edge. The shifter must settle within one cycle.
- Reset mid-operation discards S1 and the FIFO contents with no output.

## Configuration
- `SHIFT_ERR_EN` defined:
  - op codes 011 and 111 are illegal;
  - they are accepted normally, push `out_data=0` with `out_err=1`, and drive `sh_*` as SLL with amount 0.
- `SHIFT_ERR_EN` undefined:
  - the `out_err` port is absent;
  - op code bits [1:0]=11 decode as SLL/SLLV.

## Structure
- Package `shift_pkg` holds:
  - op-code localparams (`OP_SLL` … `OP_SRAV`);
  - aluc constants (`ALUC_SRA=2'b00`, `ALUC_SRL=2'b10`, `ALUC_SLL=2'b01`);
  - an entry struct type {data, tag, err}.
- Sub-module `shift_out_fifo`: 2-entry FIFO with push/pop/flush and registered `cnt`. Both S1 and the FIFO are clocked by `clk` and reset by `rst`.

## Test plan
- **Arithmetic right, immediate amount.** Drive SRA, `in_data=32'h8000_0000`, `in_amt_imm=4`, tag 3.
  - Cycle N+1: `sh_aluc=00`, `sh_b=4`.
  - Cycle N+2: `out_data=32'hF800_0000`, `out_tag=3`.
- **Variable-amount ops use only `[4:0]`.** Drive SLLV then SRLV back-to-back, `in_data=32'h0000_00FF`, `in_amt_reg=32'hFFFF_FFE8` (amount 8).
  - Expect `32'h0000_FF00`, then `32'h0000_0000`.
  - Expect consecutive `out_valid` cycles.
- **Backpressure and throughput.** Hold `out_ready=0` and stream 4 ops.
  - Exactly 3 are accepted: 2 in the FIFO, 1 in S1, and `in_ready` drops.
  - Release `out_ready`: ops drain in order, 1 per cycle, with no loss or duplication.
- **Flush with a full pipeline.** Assert `flush` for 1 cycle.
  - Next cycle: `out_valid=0`, `in_ready=1`.
  - A new SRL by 1 of `32'h2` then returns `32'h1`.
- **Reset mid-stream.** Assert `rst` while S1 and the FIFO are full.
  - All outputs read reset values the next cycle.
  - No stale result appears afterwards.
- **Illegal op with `SHIFT_ERR_EN`.** Drive op 011.
  - Expect `out_err=1`, `out_data=0`.
  - Without the macro, the same op returns SLL by `in_amt_imm`.
